sdram_frame_sched: RTL and testbench

//   Schedules the single SDRAM command port between the camera writer and the
//   TFT display reader. Issues BURST-word read bursts that fill the display FIFO
//   (fifo_tft, written via wr_fifo/sdram_data) and BURST-word camera write bursts.

---
 rtl/sdram_frame_sched.sv | 114 +++++++++++
 tb/tb_sdram_frame_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_frame_sched.sv
// sdram_frame_sched: arbitrates the SDRAM command port between display read bursts and camera write bursts,
// with double-buffered frames that swap only at a display frame boundary.
module sdram_frame_sched #(
  parameter int FRAME_W   = 320,
  parameter int FRAME_H   = 240,
  parameter int BURST     = 16,
  parameter int ADDR_W    = 22,
  parameter int FIFO_AW   = 12,
  parameter int LOW_WATER = 1024,
  parameter int BUF0_BASE = 0,
  parameter int BUF1_BASE = 131072
) (
  input  logic               clk_sdram,
  input  logic               rst_n,
  input  logic               cam_req,
  input  logic               cam_frame_start,
  output logic               cam_grant,
  input  logic [FIFO_AW-1:0] fifo_wrusedw,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               cmd_write,
  output logic [ADDR_W-1:0]  cmd_addr,
  input  logic               burst_done,
  input  logic               rd_valid,
  output logic               wr_fifo,
  output logic               disp_frame_sync,
  output logic               disp_buf,
  output logic               busy
);
  localparam int NB = FRAME_W * FRAME_H / BURST;
  localparam int PW = $clog2(NB);
  localparam int BS = $clog2(BURST);
  localparam logic [PW-1:0] LAST = PW'(NB - 1);
  localparam logic [FIFO_AW-1:0] LW = FIFO_AW'(LOW_WATER);
  localparam logic [FIFO_AW-1:0] ROOM = FIFO_AW'(2 ** FIFO_AW - 1 - 2 * BURST);
  localparam logic [ADDR_W-1:0] B0 = ADDR_W'(BUF0_BASE);
  localparam logic [ADDR_W-1:0] B1 = ADDR_W'(BUF1_BASE);

  typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

  state_t              r_state;
  logic [PW-1:0]       r_rd_ptr, r_cam_ptr;
  logic                r_cam_full, r_disp_buf, r_cmd_valid, r_cmd_write, r_busy;
  logic [ADDR_W-1:0]   r_cmd_addr;
  logic                w_urgent, w_cam, w_go_wr, w_go_rd, w_in_rd, w_done_rd, w_done_wr, w_rd_wrap;
  logic [ADDR_W-1:0]   w_rd_addr, w_cam_addr;

  assign w_urgent   = fifo_wrusedw < LW;
  assign w_cam      = cam_req && !r_cam_full;
  assign w_go_wr    = !w_urgent && w_cam;
  assign w_go_rd    = w_urgent || (!w_cam && fifo_wrusedw <= ROOM);
  assign w_rd_addr  = (r_disp_buf ? B1 : B0) + ADDR_W'({r_rd_ptr, {BS{1'b0}}});
  assign w_cam_addr = (r_disp_buf ? B0 : B1) + ADDR_W'({r_cam_ptr, {BS{1'b0}}});
  assign w_in_rd    = r_state == WAIT && !r_cmd_write;
  assign w_done_rd  = w_in_rd && burst_done;
  assign w_done_wr  = r_state == WAIT && r_cmd_write && burst_done;
  assign w_rd_wrap  = r_rd_ptr == LAST;

  assign wr_fifo         = w_in_rd && rd_valid;
  assign disp_frame_sync = w_done_rd && w_rd_wrap;
  assign cam_grant       = r_cmd_valid && cmd_ready && r_cmd_write;
  assign cmd_valid       = r_cmd_valid;
  assign cmd_write       = r_cmd_write;
  assign cmd_addr        = r_cmd_addr;
  assign disp_buf        = r_disp_buf;
  assign busy            = r_busy;

  always_ff @(posedge clk_sdram) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rd_ptr    <= '0;
      r_cam_ptr   <= '0;
      r_cam_full  <= 1'b0;
      r_disp_buf  <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_write <= 1'b0;
      r_cmd_addr  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_go_wr || w_go_rd) begin
          r_state     <= CMD;
          r_cmd_valid <= 1'b1;
          r_busy      <= 1'b1;
          r_cmd_write <= w_go_wr;
          r_cmd_addr  <= w_go_wr ? w_cam_addr : w_rd_addr;
        end
        CMD: if (cmd_ready) begin
          r_state     <= WAIT;
          r_cmd_valid <= 1'b0;
        end
        WAIT: if (burst_done) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
      // a finished camera frame is handed to the display only at the display's frame wrap
      if (w_done_rd) begin
        r_rd_ptr <= w_rd_wrap ? '0 : r_rd_ptr + PW'(1);
        if (w_rd_wrap && r_cam_full) begin
          r_disp_buf <= ~r_disp_buf;
          r_cam_full <= 1'b0;
        end
      end
      if (cam_frame_start)
        r_cam_ptr <= '0;
      else if (w_done_wr) begin
        r_cam_ptr <= (r_cam_ptr == LAST) ? '0 : r_cam_ptr + PW'(1);
        if (r_cam_ptr == LAST) r_cam_full <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sdram_frame_sched.sv
// tb_sdram_frame_sched: directed scenarios for the SDRAM frame scheduler with hand-computed addresses.
module tb_sdram_frame_sched;
  localparam int NB = 4800;
  localparam int B1 = 131072;

  logic        clk_sdram = 1'b0, rst_n = 1'b0, cam_req = 1'b0, cam_frame_start = 1'b0;
  logic        cmd_ready = 1'b0, burst_done = 1'b0, rd_valid = 1'b0;
  logic [11:0] fifo_wrusedw = '0;
  logic        cam_grant, cmd_valid, cmd_write, wr_fifo, disp_frame_sync, disp_buf, busy;
  logic [21:0] cmd_addr;

  int n_checks = 0, n_fail = 0;
  logic v, w, g, sync;
  logic [21:0] a;
  int nwf;

  sdram_frame_sched dut (
    .clk_sdram(clk_sdram), .rst_n(rst_n), .cam_req(cam_req), .cam_frame_start(cam_frame_start),
    .cam_grant(cam_grant), .fifo_wrusedw(fifo_wrusedw), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .burst_done(burst_done), .rd_valid(rd_valid),
    .wr_fifo(wr_fifo), .disp_frame_sync(disp_frame_sync), .disp_buf(disp_buf), .busy(busy)
  );

  always #5 clk_sdram = ~clk_sdram;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Plays the SDRAM controller for one burst: accepts the command, streams nd rd_valid words, then burst_done.
  task automatic burst(input int nd, input logic fs);
    nwf = 0; sync = 1'b0; g = 1'b0;
    for (int i = 0; i < 8 && cmd_valid !== 1'b1; i++) @(negedge clk_sdram);
    v = cmd_valid; w = cmd_write; a = cmd_addr;
    if (v === 1'b1) begin
      cmd_ready = 1'b1;
      #1 g = cam_grant;
      @(negedge clk_sdram);
      cmd_ready = 1'b0;
      for (int i = 0; i < nd; i++) begin
        rd_valid = 1'b1;
        #1 if (wr_fifo === 1'b1) nwf++;
        @(negedge clk_sdram);
      end
      rd_valid = 1'b0;
      burst_done = 1'b1;
      cam_frame_start = fs;
      #1 sync = disp_frame_sync;
      @(negedge clk_sdram);
      burst_done = 1'b0;
      cam_frame_start = 1'b0;
    end
  endtask

  task automatic test_reset();
    cam_req = 1'b1; cmd_ready = 1'b1; rd_valid = 1'b1; burst_done = 1'b1;
    repeat (3) begin
      @(negedge clk_sdram);
      n_checks++;
      if ({cmd_valid, cmd_write, cmd_addr, cam_grant, wr_fifo, disp_frame_sync, disp_buf, busy} !== 29'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %0h expected 0",
                 {cmd_valid, cmd_write, cmd_addr, cam_grant, wr_fifo, disp_frame_sync, disp_buf, busy});
      end
    end
    cam_req = 1'b0; cmd_ready = 1'b0; rd_valid = 1'b0; burst_done = 1'b0;
    fifo_wrusedw = 12'd0;
    rst_n = 1'b1;
  endtask

  task automatic test_read_fill();
    int k = 0;
    while (k < 2 && cmd_valid !== 1'b1) begin @(negedge clk_sdram); k++; end
    n_checks++;
    if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL first_cmd_latency: cmd_valid=%b after %0d cycles, expected 1", cmd_valid, k); end
    burst(16, 1'b0);
    n_checks++;
    if (v !== 1'b1 || w !== 1'b0 || a !== 22'd0) begin n_fail++; $display("FAIL first_read_cmd: v=%b w=%b addr=%0d expected 1 0 0", v, w, a); end
    n_checks++;
    if (nwf != 16) begin n_fail++; $display("FAIL first_read_wr_fifo: got %0d strobes expected 16", nwf); end
    n_checks++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_burst: busy=%b cmd_valid=%b expected 0 0", busy, cmd_valid); end
  endtask

  task automatic test_priority();
    fifo_wrusedw = 12'd2000; cam_req = 1'b1;
    burst(0, 1'b0);
    n_checks++;
    if (w !== 1'b1 || a !== 22'(B1) || g !== 1'b1) begin n_fail++; $display("FAIL cam_write: w=%b addr=%0d grant=%b expected 1 %0d 1", w, a, g, B1); end
    fifo_wrusedw = 12'd500;
    burst(0, 1'b0);
    n_checks++;
    if (w !== 1'b0 || a !== 22'd16 || g !== 1'b0) begin n_fail++; $display("FAIL urgent_read_wins: w=%b addr=%0d grant=%b expected 0 16 0", w, a, g); end
    fifo_wrusedw = 12'd1024;
    burst(0, 1'b0);
    n_checks++;
    if (w !== 1'b1 || a !== 22'(B1 + 16)) begin n_fail++; $display("FAIL low_water_edge_write: w=%b addr=%0d expected 1 %0d", w, a, B1 + 16); end
    fifo_wrusedw = 12'd1023;
    burst(0, 1'b0);
    n_checks++;
    if (w !== 1'b0 || a !== 22'd32) begin n_fail++; $display("FAIL low_water_edge_read: w=%b addr=%0d expected 0 32", w, a); end
    fifo_wrusedw = 12'd4063; cam_req = 1'b0;
    burst(0, 1'b0);
    n_checks++;
    if (v !== 1'b1 || w !== 1'b0 || a !== 22'd48) begin n_fail++; $display("FAIL room_edge_read: v=%b w=%b addr=%0d expected 1 0 48", v, w, a); end
    fifo_wrusedw = 12'd4064;
    begin
      logic quiet = 1'b1;
      repeat (6) begin
        @(negedge clk_sdram);
        if (cmd_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      end
      n_checks++;
      if (!quiet) begin n_fail++; $display("FAIL fifo_full_idle: cmd_valid=%b busy=%b expected 0 0", cmd_valid, busy); end
    end
  endtask

  task automatic test_cmd_stall();
    logic [21:0] a0;
    logic w0, stable;
    fifo_wrusedw = 12'd2000; cam_req = 1'b1;
    for (int i = 0; i < 8 && cmd_valid !== 1'b1; i++) @(negedge clk_sdram);
    a0 = cmd_addr; w0 = cmd_write; stable = cmd_valid;
    repeat (5) begin
      @(negedge clk_sdram);
      if (cmd_valid !== 1'b1 || cmd_addr !== a0 || cmd_write !== w0) stable = 1'b0;
    end
    n_checks++;
    if (stable !== 1'b1) begin n_fail++; $display("FAIL cmd_stable_while_stalled: v=%b addr=%0d w=%b", cmd_valid, cmd_addr, cmd_write); end
    n_checks++;
    if (w0 !== 1'b1 || a0 !== 22'(B1 + 32)) begin n_fail++; $display("FAIL stalled_write_cmd: w=%b addr=%0d expected 1 %0d", w0, a0, B1 + 32); end
    burst(3, 1'b0);
    n_checks++;
    if (nwf != 0 || g !== 1'b1) begin n_fail++; $display("FAIL write_wait_rd_valid: wr_fifo strobes=%0d grant=%b expected 0 1", nwf, g); end
  endtask

  task automatic test_reset_mid_wait();
    fifo_wrusedw = 12'd0; cam_req = 1'b0;
    for (int i = 0; i < 8 && cmd_valid !== 1'b1; i++) @(negedge clk_sdram);
    n_checks++;
    if (cmd_valid !== 1'b1 || cmd_addr !== 22'd64) begin n_fail++; $display("FAIL pre_reset_read: v=%b addr=%0d expected 1 64", cmd_valid, cmd_addr); end
    cmd_ready = 1'b1;
    @(negedge clk_sdram);
    cmd_ready = 1'b0; rd_valid = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b1 || wr_fifo !== 1'b1) begin n_fail++; $display("FAIL in_read_wait: busy=%b wr_fifo=%b expected 1 1", busy, wr_fifo); end
    rst_n = 1'b0;
    @(negedge clk_sdram);
    n_checks++;
    if ({cmd_valid, cmd_write, cmd_addr, cam_grant, wr_fifo, disp_frame_sync, disp_buf, busy} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: got %0h expected 0",
               {cmd_valid, cmd_write, cmd_addr, cam_grant, wr_fifo, disp_frame_sync, disp_buf, busy});
    end
    rd_valid = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_frame_wrap();
    fifo_wrusedw = 12'd0; cam_req = 1'b0;
    for (int i = 0; i < NB; i++) begin
      burst(0, 1'b0);
      n_checks++;
      if (v !== 1'b1 || w !== 1'b0 || a !== 22'(i * 16) || sync !== (i == NB - 1)) begin
        n_fail++;
        $display("FAIL frame_read_%0d: v=%b w=%b addr=%0d sync=%b expected 1 0 %0d %b", i, v, w, a, sync, i * 16, i == NB - 1);
      end
    end
    n_checks++;
    if (disp_buf !== 1'b0) begin n_fail++; $display("FAIL no_swap_when_not_full: disp_buf=%b expected 0", disp_buf); end
    burst(0, 1'b0);
    n_checks++;
    if (a !== 22'd0 || sync !== 1'b0) begin n_fail++; $display("FAIL read_after_wrap: addr=%0d sync=%b expected 0 0", a, sync); end
  endtask

  task automatic test_frame_start();
    fifo_wrusedw = 12'd2000; cam_req = 1'b1;
    for (int i = 0; i < NB; i++) begin
      burst(0, i == NB - 1);
      n_checks++;
      if (w !== 1'b1 || g !== 1'b1 || a !== 22'(B1 + i * 16)) begin
        n_fail++;
        $display("FAIL cam_write_%0d: w=%b grant=%b addr=%0d expected 1 1 %0d", i, w, g, a, B1 + i * 16);
      end
    end
    burst(0, 1'b0);
    n_checks++;
    if (w !== 1'b1 || g !== 1'b1 || a !== 22'(B1)) begin n_fail++; $display("FAIL frame_start_restart: w=%b grant=%b addr=%0d expected 1 1 %0d", w, g, a, B1); end
  endtask

  task automatic test_swap();
    for (int i = 1; i < NB; i++) begin
      burst(0, 1'b0);
      n_checks++;
      if (w !== 1'b1 || a !== 22'(B1 + i * 16)) begin n_fail++; $display("FAIL fill_write_%0d: w=%b addr=%0d expected 1 %0d", i, w, a, B1 + i * 16); end
    end
    n_checks++;
    if (disp_buf !== 1'b0) begin n_fail++; $display("FAIL swap_too_early: disp_buf=%b expected 0", disp_buf); end
    for (int i = 1; i < NB; i++) begin
      burst(0, 1'b0);
      n_checks++;
      if (w !== 1'b0 || g !== 1'b0 || a !== 22'(i * 16) || sync !== (i == NB - 1)) begin
        n_fail++;
        $display("FAIL stalled_cam_read_%0d: w=%b grant=%b addr=%0d sync=%b expected 0 0 %0d %b", i, w, g, a, sync, i * 16, i == NB - 1);
      end
    end
    n_checks++;
    if (disp_buf !== 1'b1) begin n_fail++; $display("FAIL swap_at_wrap: disp_buf=%b expected 1", disp_buf); end
    burst(0, 1'b0);
    n_checks++;
    if (w !== 1'b1 || g !== 1'b1 || a !== 22'd0) begin n_fail++; $display("FAIL cam_after_swap: w=%b grant=%b addr=%0d expected 1 1 0", w, g, a); end
    fifo_wrusedw = 12'd0;
    burst(0, 1'b0);
    n_checks++;
    if (w !== 1'b0 || a !== 22'(B1)) begin n_fail++; $display("FAIL read_after_swap: w=%b addr=%0d expected 0 %0d", w, a, B1); end
  endtask

  initial begin
    test_reset();
    test_read_fill();
    test_priority();
    test_cmd_stall();
    test_reset_mid_wait();
    test_frame_wrap();
    test_frame_start();
    test_swap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
